// File: rtl/risc_v_pkg.sv
// ---------------------------------------------------------------------------
// risc_v_pkg : shared core types and constants (fetch states, NOP, opcodes)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package risc_v_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : PC owner, single-outstanding imem fetch, holds instr for decode
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import risc_v_pkg::*;
#(
  parameter int unsigned       XLEN      = risc_v_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR = risc_v_pkg::NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            instr_ready_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misaligned_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] pc_inc;

  assign pc_inc = pc_q + XLEN'(4);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    misaligned_d = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    case (state_q)
      S_REQ: begin
        if (imem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          pc_d    = pc_inc;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides all sequencing; a granted-but-unreturned request
    // must still be drained so its stale data never reaches the decoder.
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      instr_d = NOP_INSTR;
      case (state_q)
        S_REQ:   state_d = imem_gnt_i    ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rvalid_i ? S_REQ   : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = imem_rvalid_i ? S_REQ   : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req_o    = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_HOLD);
  assign instr_o       = (state_q == S_HOLD) ? instr_q : NOP_INSTR;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_inc;
  assign misaligned_o  = misaligned_q;

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && (state_q == S_REQ || state_q == S_HOLD)));
  a_gnt_with_req: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_gnt_i && !imem_req_o));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed stimulus with queue-based scoreboard for instr_fetch
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misaligned;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_addr_q[$];
  exp_instr_t  exp_instr_q[$];

  instr_fetch #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_ready_i (ready),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (ivalid),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus4_o    (pc4),
    .misaligned_o  (misaligned)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: accepted requests and consumed instructions.
  always @(negedge clk) begin
    if (!rst && req && gnt) begin
      if (exp_addr_q.size() == 0) chk("unexpected_request", addr, 32'hxxxx_xxxx);
      else chk("req_addr", addr, exp_addr_q.pop_front());
    end
    if (!rst && ivalid) begin
      compared++;
      if (instr == 32'hDEAD_BEEF || instr == 32'hBAD0_0001) begin
        mismatched++;
        $display("FAIL stale_instr: got %h expected not-stale", instr);
      end
    end
    if (!rst && ivalid && ready && !redirect) begin
      if (exp_instr_q.size() == 0) chk("unexpected_consume", instr, 32'hxxxx_xxxx);
      else begin
        exp_instr_t e;
        e = exp_instr_q.pop_front();
        chk("instr", instr, e.instr);
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc4, e.pc4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_grant(input logic [31:0] exp_addr);
    int n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    if (!req) chk("grant_timeout", {31'd0, req}, 32'd1);
    else begin
      exp_addr_q.push_back(exp_addr);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
    end
  endtask

  task automatic do_resp(input logic [31:0] data);
    chk("valid_before_rvalid", {31'd0, ivalid}, 32'd0);
    rvalid = 1'b1;
    rdata  = data;
    tick();
    rvalid = 1'b0;
    chk("valid_latency", {31'd0, ivalid}, 32'd1);
  endtask

  task automatic consume(input logic [31:0] data, input logic [31:0] exp_pc, input int hold);
    exp_instr_t e;
    for (int i = 0; i < hold; i++) begin
      chk("hold_instr", instr, data);
      chk("hold_pc", pc, exp_pc);
      chk("hold_no_req", {31'd0, req}, 32'd0);
      tick();
    end
    e.instr = data;
    e.pc    = exp_pc;
    e.pc4   = exp_pc + 32'd4;
    exp_instr_q.push_back(e);
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] data, input int hold);
    do_grant(a);
    do_resp(data);
    consume(data, a, hold);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    tick();
    tick();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, ivalid}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_instr", instr, NOP);
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", addr, 32'h0);

    // basic fetch, then held for 5 cycles
    fetch(32'h0, 32'h0000_0297, 0);
    chk("next_pc", pc, 32'h4);
    fetch(32'h4, 32'h0040_0093, 5);

    // redirect while waiting; stale response two cycles later
    do_grant(32'h8);
    do_redirect(32'h100);
    chk("drain_no_req", {31'd0, req}, 32'd0);
    tick();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    chk("after_drain_valid", {31'd0, ivalid}, 32'd0);
    chk("after_drain_pc", pc, 32'h100);
    fetch(32'h100, 32'h0000_0513, 0);

    // redirect together with grant
    exp_addr_q.push_back(32'h104);
    gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    gnt = 1'b0; redirect = 1'b0;
    chk("drain2_no_req", {31'd0, req}, 32'd0);
    rvalid = 1'b1; rdata = 32'hBAD0_0001;
    tick();
    rvalid = 1'b0;
    chk("drain2_addr", addr, 32'h200);

    // redirect together with ready in hold: no +4
    do_grant(32'h200);
    do_resp(32'h0000_0617);
    ready = 1'b1;
    do_redirect(32'h300);
    ready = 1'b0;
    chk("hold_redirect_pc", pc, 32'h300);
    chk("hold_redirect_valid", {31'd0, ivalid}, 32'd0);
    fetch(32'h300, 32'h0000_0693, 0);

    // misaligned redirect target
    chk("misaligned_idle", {31'd0, misaligned}, 32'd0);
    do_redirect(32'h102);
    chk("misaligned_pulse", {31'd0, misaligned}, 32'd1);
    chk("misaligned_addr", addr, 32'h100);
    tick();
    chk("misaligned_clear", {31'd0, misaligned}, 32'd0);
    fetch(32'h100, 32'h0000_0713, 0);

    // PC wrap
    do_redirect(32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0793, 0);
    chk("wrap_pc", pc, 32'h0);
    fetch(32'h0, 32'h0000_0813, 0);

    // reset while waiting for a response
    do_grant(32'h4);
    rst = 1'b1;
    tick();
    chk("midrst_req", {31'd0, req}, 32'd0);
    chk("midrst_valid", {31'd0, ivalid}, 32'd0);
    rst = 1'b0;
    chk("midrst_addr", addr, 32'h0);
    fetch(32'h0, 32'h0000_0893, 0);

    tick();
    chk("addr_q_empty", exp_addr_q.size(), 32'd0);
    chk("instr_q_empty", exp_instr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
